// File: rtl/mips_defines.sv
// Shared MIPS core widths; the register-file write arbiter and its buffer size themselves from these.
package mips_defines;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_wport_arb_pkg.sv
// Types local to the register-file write-port arbiter.
package reg_wport_arb_pkg;
  import mips_defines::*;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_t;

  localparam int WAIT_W = 3;
endpackage

// File: rtl/reg_wport_arb_if.sv
// Bus bundle between the pipeline / multicycle units (master) and the write-port arbiter (slave).
interface reg_wport_arb_if;
  import mips_defines::*;

  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0]     wb_wdata;
  logic                  md_valid;
  logic                  md_ready;
  logic [REG_ADDR_W-1:0] md_waddr;
  logic [DATA_W-1:0]     md_wdata;
  logic                  we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [DATA_W-1:0]     wdata;
  logic [REG_ADDR_W-1:0] chk_addr1;
  logic [REG_ADDR_W-1:0] chk_addr2;
  logic                  hz1;
  logic                  hz2;
  logic                  stall_req;
  logic [1:0]            buf_count;

  modport master (
    output wb_we, wb_waddr, wb_wdata, md_valid, md_waddr, md_wdata, chk_addr1, chk_addr2,
    input  md_ready, we, waddr, wdata, hz1, hz2, stall_req, buf_count
  );
  modport slave (
    input  wb_we, wb_waddr, wb_wdata, md_valid, md_waddr, md_wdata, chk_addr1, chk_addr2,
    output md_ready, we, waddr, wdata, hz1, hz2, stall_req, buf_count
  );
endinterface

// File: rtl/wport_fifo2.sv
// Two-entry in-order write buffer. Entries stay compacted toward slot 0 (the head),
// so vld is always 00, 01 or 11; squash-by-address can remove either slot.
module wport_fifo2
  import mips_defines::*, reg_wport_arb_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  wr_t                         push_ent,
  input  logic                        pop,
  input  logic                        sq_en,
  input  logic [REG_ADDR_W-1:0]       sq_addr,
  output wr_t                         head,
  output logic [1:0][REG_ADDR_W-1:0]  addrs,
  output logic [1:0]                  vld,
  output logic                        head_sq,
  output logic [1:0]                  count
);
  wr_t [1:0]  ent_q, ent_d;
  logic [1:0] vld_q, vld_d, keep;

  always_comb begin
    for (int i = 0; i < 2; i++)
      keep[i] = vld_q[i] && !(sq_en && ent_q[i].addr == sq_addr);
    keep[0] = keep[0] && !pop;

    ent_d = ent_q;
    vld_d = '0;
    // Survivors slide down so the oldest remaining entry is always in slot 0.
    if (keep[0]) begin
      vld_d = {keep[1], 1'b1};
    end else if (keep[1]) begin
      ent_d[0] = ent_q[1];
      vld_d[0] = 1'b1;
    end

    if (push) begin
      if (!vld_d[0]) begin
        ent_d[0] = push_ent;
        vld_d[0] = 1'b1;
      end else begin
        ent_d[1] = push_ent;
        vld_d[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
    ent_q <= ent_d;
  end

  assign head    = ent_q[0];
  assign addrs   = {ent_q[1].addr, ent_q[0].addr};
  assign vld     = vld_q;
  assign head_sq = vld_q[0] && sq_en && (ent_q[0].addr == sq_addr);
  assign count   = vld_q[1] ? 2'd2 : {1'b0, vld_q[0]};
endmodule

// File: rtl/reg_wport_arb.sv
// Single register-file write port shared between pipeline writeback (always wins) and
// multicycle units, whose writes wait in a 2-entry buffer with hazard and starvation reporting.
module reg_wport_arb
  import mips_defines::*, reg_wport_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  reg_wport_arb_if.slave    bus
);
  localparam logic [WAIT_W-1:0] LIM = WAIT_W'(STARVE_LIMIT);

  wr_t                        head;
  logic [1:0][REG_ADDR_W-1:0] addrs;
  logic [1:0]                 vld, count;
  logic                       head_sq, wb_wr, pop, push, rdy;
  logic [WAIT_W-1:0]          wait_q;
  logic                       stall_q;

  assign wb_wr = bus.wb_we && (bus.wb_waddr != ZERO_REG);
  assign rdy   = !rst && (count != 2'd2);
  assign pop   = !rst && !wb_wr && (count != 2'd0);
  // An md write racing a wb write to the same register is older, so it is simply dropped.
  assign push  = bus.md_valid && rdy && (bus.md_waddr != ZERO_REG) &&
                 !(wb_wr && bus.md_waddr == bus.wb_waddr);

  wport_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_ent ('{addr: bus.md_waddr, data: bus.md_wdata}),
    .pop      (pop),
    .sq_en    (wb_wr),
    .sq_addr  (bus.wb_waddr),
    .head     (head),
    .addrs    (addrs),
    .vld      (vld),
    .head_sq  (head_sq),
    .count    (count)
  );

  always_comb begin
    bus.we    = 1'b0;
    bus.waddr = ZERO_REG;
    bus.wdata = '0;
    if (!rst && wb_wr) begin
      bus.we    = 1'b1;
      bus.waddr = bus.wb_waddr;
      bus.wdata = bus.wb_wdata;
    end else if (pop) begin
      bus.we    = 1'b1;
      bus.waddr = head.addr;
      bus.wdata = head.data;
    end
  end

  always_comb begin
    bus.hz1 = 1'b0;
    bus.hz2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (vld[i] && addrs[i] == bus.chk_addr1) bus.hz1 = 1'b1;
      if (vld[i] && addrs[i] == bus.chk_addr2) bus.hz2 = 1'b1;
    end
    if (rst || bus.chk_addr1 == ZERO_REG) bus.hz1 = 1'b0;
    if (rst || bus.chk_addr2 == ZERO_REG) bus.hz2 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      if (count == 2'd0 || pop || head_sq) wait_q <= '0;
      else if (wait_q != '1)               wait_q <= wait_q + 1'b1;

      // An empty buffer has nothing left to drain, so the stall is dropped too.
      if (pop || count == 2'd0)                                 stall_q <= 1'b0;
      else if (wait_q >= LIM || (count == 2'd2 && bus.md_valid)) stall_q <= 1'b1;
    end
  end

  assign bus.md_ready  = rdy;
  assign bus.buf_count = count;
  assign bus.stall_req = stall_q;
endmodule
